// File: rtl/set_button_defs.sv
// rtl/set_button_defs.sv - shared state codes and default timing for the set-button controller
//
// Package set_button_defs
//   mode_e               : FSM state codes RUN=0, SEC=1, MIN=2, HOUR=3
//   DEF_DEBOUNCE_CYCLES  : default stable cycles before a new button level is accepted
//   DEF_REPEAT_DELAY     : default cycles from the first INCR to the first auto-repeat INCR
//   DEF_REPEAT_PERIOD    : default cycles between auto-repeat INCR pulses
//   next_mode()          : RUN -> SEC -> MIN -> HOUR -> RUN
package set_button_defs;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_SEC  = 2'd1,
    ST_MIN  = 2'd2,
    ST_HOUR = 2'd3
  } mode_e;

  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_REPEAT_DELAY    = 64;
  localparam int DEF_REPEAT_PERIOD   = 16;

  function automatic mode_e next_mode(input mode_e m);
    // Four states in two bits: the increment wraps HOUR back to RUN.
    return mode_e'(m + 2'd1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-flop synchroniser, counting debouncer and rising-edge pulse for one button
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive differing synchronised cycles needed to accept a new level (>= 1)
// Ports
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   btn    : raw asynchronous button level
//   level  : debounced button level
//   rise   : one-cycle pulse, registered together with level going 0 -> 1
module btn_debounce
  import set_button_defs::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= 2'b00;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      rise <= 1'b0;
      if (sync[1] != level) begin
        // The edge that would take the count to DEBOUNCE_CYCLES accepts the
        // new level instead; any return to the old level restarts the count.
        if (cnt == LAST) begin
          level <= sync[1];
          rise  <= sync[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/set_button_ctrl.sv
// rtl/set_button_ctrl.sv - mode/increment button controller for setting a clock counter
//
// Optional feature: define SET_BTN_AUTOREPEAT_EN to auto-repeat INCR while BTN_UP is held.
// Parameters
//   DEBOUNCE_CYCLES : debounce length for both buttons
//   REPEAT_DELAY    : cycles from the first INCR to the first repeat (auto-repeat build only)
//   REPEAT_PERIOD   : cycles between repeats, must be >= 2 (auto-repeat build only)
// Ports
//   CLOCK_CLK   : clock
//   CLOCK_RST_N : asynchronous active-low reset
//   BTN_MODE    : raw mode button
//   BTN_UP      : raw increment button
//   SET_SEC     : high in SEC state
//   SET_MIN     : high in MIN state
//   SET_HOUR    : high in HOUR state
//   INCR        : one-cycle increment pulse
//   MODE        : current state code
module set_button_ctrl
  import set_button_defs::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic       CLOCK_CLK,
  input  logic       CLOCK_RST_N,
  input  logic       BTN_MODE,
  input  logic       BTN_UP,
  output logic       SET_SEC,
  output logic       SET_MIN,
  output logic       SET_HOUR,
  output logic       INCR,
  output logic [1:0] MODE
);

  // A period of one would put two INCR pulses back to back.
  localparam bit REPEAT_CFG_OK = (REPEAT_PERIOD >= 2) && (REPEAT_DELAY >= 2);
  if (!REPEAT_CFG_OK) begin : g_repeat_cfg_invalid
  end

  logic mode_level, mode_rise;
  logic up_level, up_rise;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_btn (
    .clk   (CLOCK_CLK),
    .rst_n (CLOCK_RST_N),
    .btn   (BTN_MODE),
    .level (mode_level),
    .rise  (mode_rise)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up_btn (
    .clk   (CLOCK_CLK),
    .rst_n (CLOCK_RST_N),
    .btn   (BTN_UP),
    .level (up_level),
    .rise  (up_rise)
  );

  mode_e state_q, state_d;
  logic  incr_d;

`ifdef SET_BTN_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCW     = $clog2(REP_MAX + 1);
  localparam logic [RCW-1:0] DELAY_LAST  = RCW'(REPEAT_DELAY - 1);
  localparam logic [RCW-1:0] PERIOD_LAST = RCW'(REPEAT_PERIOD - 1);

  logic           rep_active_q, rep_active_d;
  logic           rep_phase_q, rep_phase_d;  // 0: waiting out the delay, 1: periodic
  logic [RCW-1:0] rep_cnt_q, rep_cnt_d;
  logic [RCW-1:0] rep_target;

  assign rep_target = rep_phase_q ? PERIOD_LAST : DELAY_LAST;
`endif

  always_comb begin
    state_d = state_q;
    incr_d  = 1'b0;
`ifdef SET_BTN_AUTOREPEAT_EN
    rep_active_d = rep_active_q;
    rep_phase_d  = rep_phase_q;
    rep_cnt_d    = rep_cnt_q;
`endif
    if (mode_rise) begin
      // A mode edge wins over a simultaneous UP edge and ends any repeat; a
      // held UP then needs a fresh debounced press to increment again.
      state_d = next_mode(state_q);
`ifdef SET_BTN_AUTOREPEAT_EN
      rep_active_d = 1'b0;
`endif
    end else if (state_q != ST_RUN && up_rise) begin
      incr_d = 1'b1;
`ifdef SET_BTN_AUTOREPEAT_EN
      rep_active_d = 1'b1;
      rep_phase_d  = 1'b0;
      rep_cnt_d    = '0;
`endif
    end
`ifdef SET_BTN_AUTOREPEAT_EN
    else if (state_q != ST_RUN && rep_active_q && up_level) begin
      if (rep_cnt_q == rep_target) begin
        incr_d      = 1'b1;
        rep_phase_d = 1'b1;
        rep_cnt_d   = '0;
      end else begin
        rep_cnt_d = rep_cnt_q + 1'b1;
      end
    end else begin
      rep_active_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge CLOCK_CLK or negedge CLOCK_RST_N) begin
    if (!CLOCK_RST_N) begin
      state_q  <= ST_RUN;
      INCR     <= 1'b0;
      SET_SEC  <= 1'b0;
      SET_MIN  <= 1'b0;
      SET_HOUR <= 1'b0;
    end else begin
      state_q  <= state_d;
      INCR     <= incr_d;
      SET_SEC  <= (state_d == ST_SEC);
      SET_MIN  <= (state_d == ST_MIN);
      SET_HOUR <= (state_d == ST_HOUR);
    end
  end

`ifdef SET_BTN_AUTOREPEAT_EN
  always_ff @(posedge CLOCK_CLK or negedge CLOCK_RST_N) begin
    if (!CLOCK_RST_N) begin
      rep_active_q <= 1'b0;
      rep_phase_q  <= 1'b0;
      rep_cnt_q    <= '0;
    end else begin
      rep_active_q <= rep_active_d;
      rep_phase_q  <= rep_phase_d;
      rep_cnt_q    <= rep_cnt_d;
    end
  end
`endif

  assign MODE = state_q;

endmodule

// File: tb/tb_set_button_ctrl.sv
// tb/tb_set_button_ctrl.sv - self-checking bench for set_button_ctrl against a behavioural model
module tb_set_button_ctrl;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_up = 1'b0;
  logic       set_sec, set_min, set_hour, incr;
  logic [1:0] mode;

  always #5 clk = ~clk;

  set_button_ctrl #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .CLOCK_CLK   (clk),
    .CLOCK_RST_N (rst_n),
    .BTN_MODE    (btn_mode),
    .BTN_UP      (btn_up),
    .SET_SEC     (set_sec),
    .SET_MIN     (set_min),
    .SET_HOUR    (set_hour),
    .INCR        (incr),
    .MODE        (mode)
  );

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  int incr_count = 0;

  // Reference model: raw samples per edge (bit 0 newest), debounced levels,
  // edge flags, mode number and repeat timing in cycles since the first INCR.
  logic [D+1:0] hm, hu;
  bit m_deb, u_deb, m_rise, u_rise;
  int m_mode;
  bit m_incr;
  bit rep_on;
  int t_since;
  bit prev_incr_obs;

  // A new level is accepted once the last D synchronised samples (which lag
  // the raw samples by two edges) all disagree with the current level.
  function automatic bit settles(input logic [D+1:0] h, input bit lvl);
    logic [D-1:0] w;
    w = h[D+1:2];
    return lvl ? (w == '0) : (w == '1);
  endfunction

  task automatic model_reset();
    hm = '0; hu = '0;
    m_deb = 0; u_deb = 0; m_rise = 0; u_rise = 0;
    m_mode = 0; m_incr = 0; rep_on = 0; t_since = 0;
    prev_incr_obs = 0;
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_rise) begin
      m_mode = (m_mode + 1) % 4;
      m_incr = 0;
      rep_on = 0;
    end else if (m_mode != 0 && u_rise) begin
      m_incr = 1;
`ifdef SET_BTN_AUTOREPEAT_EN
      rep_on  = 1;
      t_since = 0;
`endif
    end else if (rep_on && u_deb && m_mode != 0) begin
      t_since = t_since + 1;
      m_incr = (t_since == RD) || (t_since > RD && ((t_since - RD) % RP) == 0);
    end else begin
      rep_on = 0;
      m_incr = 0;
    end
    hm = {hm[D:0], btn_mode};
    hu = {hu[D:0], btn_up};
    m_rise = 0;
    u_rise = 0;
    if (settles(hm, m_deb)) begin m_deb = ~m_deb; m_rise = m_deb; end
    if (settles(hu, u_deb)) begin u_deb = ~u_deb; u_rise = u_deb; end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("MODE", {30'd0, mode}, m_mode);
    chk("SET_SEC", {31'd0, set_sec}, int'(m_mode == 1));
    chk("SET_MIN", {31'd0, set_min}, int'(m_mode == 2));
    chk("SET_HOUR", {31'd0, set_hour}, int'(m_mode == 3));
    chk("INCR", {31'd0, incr}, int'(m_incr));
    chk("INCR_back_to_back", {31'd0, prev_incr_obs & incr}, 0);
    prev_incr_obs = incr;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    if (incr === 1'b1) incr_count++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press_mode();
    btn_mode = 1'b1; ticks(10);
    btn_mode = 1'b0; ticks(8);
  endtask

  task automatic press_up();
    btn_up = 1'b1; ticks(10);
    btn_up = 1'b0; ticks(8);
  endtask

  // Called just after an edge: reset drops mid-cycle, outputs must clear
  // before the next edge, and release happens away from an edge.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("RST_MODE", {30'd0, mode}, 0);
    chk("RST_SET", {29'd0, set_sec, set_min, set_hour}, 0);
    chk("RST_INCR", {31'd0, incr}, 0);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    ticks(3);
    chk("reset_MODE", {30'd0, mode}, 0);
    rst_n = 1'b1;
    ticks(2);

    // Mode press: MODE changes in the cycle after the 7th sampling edge.
    btn_mode = 1'b1;
    ticks(6);
    chk("lat_MODE_before", {30'd0, mode}, 0);
    tick();
    chk("lat_MODE_after", {30'd0, mode}, 1);
    chk("lat_SET_SEC", {31'd0, set_sec}, 1);
    ticks(3);
    btn_mode = 1'b0;
    ticks(8);
    press_mode();
    press_mode();
    press_mode();
    chk("wrap_MODE", {30'd0, mode}, 0);
    chk("wrap_SET", {29'd0, set_sec, set_min, set_hour}, 0);

    // UP ignored in RUN.
    incr_count = 0;
    press_up();
    chk("run_incr_count", incr_count, 0);

    // SEC: short glitch then a clean press.
    press_mode();
    incr_count = 0;
    btn_up = 1'b1; ticks(3);
    btn_up = 1'b0; ticks(8);
    chk("glitch_incr_count", incr_count, 0);
    press_up();
    chk("clean_incr_count", incr_count, 1);

    // MIN: MODE and UP rise together; held UP must not increment.
    press_mode();
    incr_count = 0;
    btn_mode = 1'b1; btn_up = 1'b1; ticks(10);
    btn_mode = 1'b0; ticks(30);
    chk("simul_MODE", {30'd0, mode}, 3);
    chk("simul_incr_count", incr_count, 0);
    btn_up = 1'b0; ticks(8);
    chk("release_incr_count", incr_count, 0);
    press_up();
    chk("repress_incr_count", incr_count, 1);

    // HOUR: long hold.
    incr_count = 0;
    btn_up = 1'b1; ticks(60);
    btn_up = 1'b0; ticks(10);
`ifdef SET_BTN_AUTOREPEAT_EN
    chk("hold_incr_count", incr_count, 6);
`else
    chk("hold_incr_count", incr_count, 1);
`endif

    // HOUR -> RUN -> SEC -> MIN, hold UP, reset mid-repeat.
    press_mode();
    press_mode();
    press_mode();
    chk("pre_rst_MODE", {30'd0, mode}, 2);
    btn_up = 1'b1; ticks(30);
    async_reset();
    ticks(15);
    chk("post_rst_MODE", {30'd0, mode}, 0);
    btn_up = 1'b0; ticks(8);

    // Random segments with glitches, clean presses and occasional resets.
    for (int s = 0; s < 400; s++) begin
      btn_mode = ($urandom_range(0, 3) == 0);
      btn_up   = ($urandom_range(0, 1) == 1);
      ticks($urandom_range(1, 12));
      if ($urandom_range(0, 59) == 0) async_reset();
    end
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    ticks(12);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
